// File: rtl/fifo_pkg.sv
// Shared defaults and sizing helpers for the parameterised synchronous FIFO.
package fifo_pkg;

  localparam int unsigned FIFO_DATA_W_DEF   = 8;
  localparam int unsigned FIFO_DEPTH_DEF    = 16;
  localparam int unsigned FIFO_AE_LEVEL_DEF = 2;
  localparam int unsigned FIFO_FWFT_DEF     = 0;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous read port.
module fifo_mem #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output logic [DATA_W-1:0]        rd_data_c
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_c = mem_q[rd_addr_i];

endmodule

// File: rtl/param_sync_fifo.sv
// Parameterised single-clock FIFO with threshold flags, sticky error flags and
// selectable standard / first-word-fall-through read behaviour.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W   = FIFO_DATA_W_DEF,
  parameter int unsigned DEPTH    = FIFO_DEPTH_DEF,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = FIFO_AE_LEVEL_DEF,
  parameter int unsigned FWFT     = FIFO_FWFT_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic                      rd_en,
  input  logic                      clr_err,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      rd_valid,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);

  // Elaboration-time parameter legality.
  if (DATA_W < 1 || DATA_W > 64) begin : g_bad_data_w
    $error("param_sync_fifo: DATA_W must be 1..64");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("param_sync_fifo: DEPTH must be a power of two >= 2");
  end
  if (!(AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH)) begin : g_bad_levels
    $error("param_sync_fifo: need AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              af_q, af_d;
  logic              ae_q, ae_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [DATA_W-1:0] head_data;
  logic              wr_acc;
  logic              rd_acc;

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (wr_acc),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (wr_data),
    .rd_addr_i (rd_ptr_q),
    .rd_data_c (head_data)
  );

  // Next-state: accept/reject decisions use the registered full/empty flags.
  always_comb begin
    wr_acc     = wr_en && !full_q;
    rd_acc     = rd_en && !empty_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_acc;

    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc) begin
      rd_ptr_d  = rd_ptr_q + AW'(1);
      rd_data_d = head_data;
    end

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
    af_d    = (count_d >= CW'(AF_LEVEL));
    ae_d    = (count_d <= CW'(AE_LEVEL));

    // A new error event wins over a simultaneous clear.
    ovf_d = (wr_en && full_q)  || (ovf_q && !clr_err);
    udf_d = (rd_en && empty_q) || (udf_q && !clr_err);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      af_q       <= 1'b0;
      ae_q       <= 1'b1;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      af_q       <= af_d;
      ae_q       <= ae_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // FWFT exposes the head entry directly; standard mode uses the popped-word register.
  assign rd_data      = (FWFT != 0) ? (empty_q ? '0 : head_data) : rd_data_q;
  assign rd_valid     = (FWFT != 0) ? !empty_q : rd_valid_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench for param_sync_fifo: vector table plus multi-cycle corner sequences.
module tb_param_sync_fifo;

  localparam int unsigned DW = 8;
  localparam int unsigned DP = 16;
  localparam int unsigned CW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en, rd_en, clr_err;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data;
  logic          rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [CW-1:0] count;

  logic          wr_f, rd_f, clr_f;
  logic [DW-1:0] wdata_f, rdata_f;
  logic          rv_f, full_f, empty_f, af_f, ae_f, ovf_f, udf_f;
  logic [CW-1:0] cnt_f;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  param_sync_fifo #(.DATA_W(DW), .DEPTH(DP), .FWFT(0)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .clr_err(clr_err), .rd_data(rd_data), .rd_valid(rd_valid), .full(full),
    .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  param_sync_fifo #(.DATA_W(DW), .DEPTH(DP), .FWFT(1)) dut_f (
    .clk(clk), .rst(rst), .wr_en(wr_f), .wr_data(wdata_f), .rd_en(rd_f),
    .clr_err(clr_f), .rd_data(rdata_f), .rd_valid(rv_f), .full(full_f),
    .empty(empty_f), .almost_full(af_f), .almost_empty(ae_f),
    .count(cnt_f), .overflow(ovf_f), .underflow(udf_f)
  );

  typedef struct {
    logic          wr;
    logic          rd;
    logic          clr;
    logic [DW-1:0] d;
    logic [CW-1:0] cnt;
    logic          emp;
    logic          ae;
    logic          ovf;
    logic          udf;
    logic          rv;
    logic [DW-1:0] rdat;
  } vec_t;

  vec_t          vt[14];
  logic [DW-1:0] q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wr_data = '0;
    wr_f = 1'b0; rd_f = 1'b0; clr_f = 1'b0; wdata_f = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) begin
      wr_en = 1'b1; wr_data = DW'(i);
      tick();
    end
    wr_en = 1'b0;
  endtask

  initial begin
    vt[0]  = '{1'b1, 1'b0, 1'b0, 8'h11, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[1]  = '{1'b1, 1'b0, 1'b0, 8'h22, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[2]  = '{1'b1, 1'b0, 1'b0, 8'h33, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[3]  = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11};
    vt[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h11};
    vt[5]  = '{1'b1, 1'b1, 1'b0, 8'h44, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h22};
    vt[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h33};
    vt[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h44};
    vt[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h44};
    vt[9]  = '{1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h44};
    vt[10] = '{1'b0, 1'b1, 1'b1, 8'h00, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h44};
    vt[11] = '{1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h44};
    vt[12] = '{1'b1, 1'b1, 1'b0, 8'h55, 5'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h44};
    vt[13] = '{1'b0, 1'b1, 1'b1, 8'h00, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h55};

    // Reset state
    do_reset();
    chk("rst.count", 64'(count), 0);
    chk("rst.empty", 64'(empty), 1);
    chk("rst.ae", 64'(almost_empty), 1);
    chk("rst.full", 64'(full), 0);
    chk("rst.af", 64'(almost_full), 0);
    chk("rst.rv", 64'(rd_valid), 0);
    chk("rst.rdata", 64'(rd_data), 0);

    // Vector table
    for (int i = 0; i < 14; i++) begin
      wr_en = vt[i].wr; rd_en = vt[i].rd; clr_err = vt[i].clr; wr_data = vt[i].d;
      tick();
      chk($sformatf("vec%0d.cnt", i), 64'(count), 64'(vt[i].cnt));
      chk($sformatf("vec%0d.empty", i), 64'(empty), 64'(vt[i].emp));
      chk($sformatf("vec%0d.ae", i), 64'(almost_empty), 64'(vt[i].ae));
      chk($sformatf("vec%0d.ovf", i), 64'(overflow), 64'(vt[i].ovf));
      chk($sformatf("vec%0d.udf", i), 64'(underflow), 64'(vt[i].udf));
      chk($sformatf("vec%0d.rv", i), 64'(rd_valid), 64'(vt[i].rv));
      chk($sformatf("vec%0d.rdata", i), 64'(rd_data), 64'(vt[i].rdat));
    end
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;

    // Fill, then overflow attempt
    do_reset();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = DW'(i);
      tick();
      chk($sformatf("fill%0d.cnt", i), 64'(count), 64'(i + 1));
      chk($sformatf("fill%0d.af", i), 64'(almost_full), 64'((i + 1) >= 14));
      chk($sformatf("fill%0d.full", i), 64'(full), 64'((i + 1) == 16));
    end
    wr_data = 8'hEE;
    tick();
    wr_en = 1'b0;
    chk("fill.ovf", 64'(overflow), 1);
    chk("fill.cnt16", 64'(count), 16);

    // Drain, underflow, clear
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1;
      tick();
      chk($sformatf("drain%0d.rdata", i), 64'(rd_data), 64'(i));
      chk($sformatf("drain%0d.rv", i), 64'(rd_valid), 1);
      chk($sformatf("drain%0d.cnt", i), 64'(count), 64'(15 - i));
    end
    chk("drain.empty", 64'(empty), 1);
    tick();
    rd_en = 1'b0;
    chk("drain.udf", 64'(underflow), 1);
    chk("drain.rv0", 64'(rd_valid), 0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("clr.udf", 64'(underflow), 0);
    chk("clr.ovf", 64'(overflow), 0);

    // Wrap: occupancy held between 3 and 5
    do_reset();
    q.delete();
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = DW'(8'h80 + i);
      q.push_back(DW'(8'h80 + i));
      tick();
    end
    for (int i = 0; i < 40; i++) begin
      logic w, r;
      logic [DW-1:0] wd, exp_d;
      wd = DW'(8'h90 + i);
      if (q.size() >= 5)      begin w = 1'b0; r = 1'b1; end
      else if (q.size() <= 3) begin w = 1'b1; r = 1'b0; end
      else begin
        case (i % 3)
          0:       begin w = 1'b1; r = 1'b0; end
          1:       begin w = 1'b1; r = 1'b1; end
          default: begin w = 1'b0; r = 1'b1; end
        endcase
      end
      wr_en = w; rd_en = r; wr_data = wd;
      tick();
      if (r) begin
        exp_d = q.pop_front();
        chk($sformatf("wrap%0d.rdata", i), 64'(rd_data), 64'(exp_d));
      end
      if (w) q.push_back(wd);
      chk($sformatf("wrap%0d.rv", i), 64'(rd_valid), 64'(r));
      chk($sformatf("wrap%0d.cnt", i), 64'(count), 64'(q.size()));
    end
    wr_en = 1'b0; rd_en = 1'b0;

    // Simultaneous read/write at full and mid-level
    do_reset();
    fill(16);
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h77;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("fullrw.cnt", 64'(count), 15);
    chk("fullrw.ovf", 64'(overflow), 1);
    chk("fullrw.full", 64'(full), 0);
    chk("fullrw.rdata", 64'(rd_data), 0);
    do_reset();
    fill(8);
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h88;
    tick();
    wr_en = 1'b0;
    chk("midrw.cnt", 64'(count), 8);
    chk("midrw.rdata", 64'(rd_data), 0);
    for (int i = 1; i < 9; i++) begin
      tick();
      chk($sformatf("midrw.rd%0d", i), 64'(rd_data), (i == 8) ? 64'h88 : 64'(i));
    end
    rd_en = 1'b0;

    // FWFT instance
    do_reset();
    chk("fwft.rst.rv", 64'(rv_f), 0);
    chk("fwft.rst.rdata", 64'(rdata_f), 0);
    wr_f = 1'b1; wdata_f = 8'hA5;
    tick();
    wr_f = 1'b0;
    chk("fwft.rv", 64'(rv_f), 1);
    chk("fwft.rdata", 64'(rdata_f), 64'hA5);
    chk("fwft.cnt", 64'(cnt_f), 1);
    tick();
    chk("fwft.hold.rv", 64'(rv_f), 1);
    rd_f = 1'b1;
    tick();
    rd_f = 1'b0;
    chk("fwft.pop.empty", 64'(empty_f), 1);
    chk("fwft.pop.rv", 64'(rv_f), 0);
    chk("fwft.pop.cnt", 64'(cnt_f), 0);

    // Reset mid-operation with wr_en high
    do_reset();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    fill(10);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("mid.cnt9", 64'(count), 9);
    chk("mid.udf", 64'(underflow), 1);
    rst = 1'b1; wr_en = 1'b1; wr_data = 8'hFF;
    tick();
    rst = 1'b0; wr_en = 1'b0;
    chk("mrst.cnt", 64'(count), 0);
    chk("mrst.empty", 64'(empty), 1);
    chk("mrst.ae", 64'(almost_empty), 1);
    chk("mrst.full", 64'(full), 0);
    chk("mrst.af", 64'(almost_full), 0);
    chk("mrst.rv", 64'(rd_valid), 0);
    chk("mrst.rdata", 64'(rd_data), 0);
    chk("mrst.ovf", 64'(overflow), 0);
    chk("mrst.udf", 64'(underflow), 0);
    wr_en = 1'b1; wr_data = 8'h3C;
    tick();
    wr_en = 1'b0; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("mrst.newdata", 64'(rd_data), 64'h3C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8: data width in bits, legal range 1 to 64.
REQ-002 SHALL have parameter DEPTH, default 16: number of entries, a power of two, at least 2.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2: almost_full asserts when count >= AF_LEVEL.
REQ-004 SHALL have parameter AE_LEVEL, default 2: almost_empty asserts when count <= AE_LEVEL.
REQ-005 SHALL have parameter FWFT, default 0: 0 selects standard read mode, 1 selects first-word-fall-through.
REQ-006 SHALL have a single clock and a synchronous, active-high reset, with ports as follows.
- clk  input  1  rising-edge clock for all state
- rst  input  1  synchronous active-high reset
- wr_en  input  1  write request
- wr_data  input  DATA_W  write data
- rd_en  input  1  read/pop request
- clr_err  input  1  clears the sticky error flags
- rd_data  output  DATA_W  read data
- rd_valid  output  1  rd_data qualifier
- full, empty  output  1 each  occupancy flags
- almost_full, almost_empty  output  1 each  threshold flags
- count  output  $clog2(DEPTH)+1  current occupancy, 0 to DEPTH
- overflow, underflow  output  1 each  sticky error flags

Function
REQ-007 SHALL accept a write when wr_en && !full; accepted data is stored at the write pointer, which then increments modulo DEPTH.
REQ-008 SHALL accept a read when rd_en && !empty; the read pointer then increments modulo DEPTH.
REQ-009 SHALL reject a write while full, even if a read is accepted in the same cycle; the FIFO state is unchanged by the rejected write.
REQ-010 SHALL reject a read while empty, even if a write is accepted in the same cycle.
REQ-011 SHALL, when a read and a write are both accepted in one cycle, leave count unchanged and keep both transfers.
REQ-012 SHALL update count on the edge following each accepted transfer: +1 for a write only, -1 for a read only.
REQ-013 SHALL drive full, empty, almost_full and almost_empty as registered outputs, each consistent with count in the same cycle.
REQ-014 SHALL set overflow on wr_en && full and set underflow on rd_en && empty; both hold until clr_err or rst.
REQ-015 SHALL, if clr_err and a new error event occur in the same cycle, set the flag (the set wins).
REQ-016 SHALL, in FWFT=0, present the popped word on rd_data one cycle after the accepted read, pulse rd_valid for that one cycle, and hold rd_data otherwise.
REQ-017 SHALL, in FWFT=1, drive rd_data with the head entry whenever !empty, drive rd_valid = !empty, and have rd_en pop the head.
REQ-018 SHALL, in FWFT=1, make a word written into an empty FIFO visible on rd_data/rd_valid exactly one cycle after the write.
REQ-019 SHALL handle pointer wrap-around seamlessly; data order is strictly FIFO across any number of wraps.

Reset
REQ-020 SHALL, on rst high at a clock edge, set pointers=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, rd_valid=0, rd_data=0, overflow=0, underflow=0.
REQ-021 SHALL give rst priority over all other inputs; a reset mid-operation discards all stored data and ignores any simultaneous wr_en/rd_en.
REQ-022 SHALL not require the storage array to be cleared on reset.

Structure
REQ-023 SHALL place the default parameter values and a count-width helper function in a shared package, fifo_pkg.
REQ-024 SHALL implement storage in one sub-module, fifo_mem: DEPTH x DATA_W, one synchronous write port and one asynchronous read port addressed by the read pointer.
REQ-025 SHALL check parameter legality at elaboration (DEPTH power of two, AE_LEVEL < AF_LEVEL <= DEPTH).

Verification (DATA_W=8, DEPTH=16)
REQ-026 Fill test: write 0x00..0x0F with no reads -> full=1, count=16, almost_full from count 14; a 17th write sets overflow and leaves the contents unchanged.
REQ-027 Drain test: after a fill, read 16 words -> data 0x00..0x0F in order, empty=1; a further rd_en sets underflow; clr_err then clears it.
REQ-028 Wrap test: 40 interleaved writes/reads with occupancy held at 3 to 5 -> data in order across the pointer wrap, count correct every cycle.
REQ-029 Full-boundary simultaneous test: at full, wr_en=rd_en=1 -> read accepted, write rejected, count=15, overflow=1; at count 8, both -> count stays 8.
REQ-030 FWFT=1 test: write 0xA5 into an empty FIFO -> rd_valid=1 and rd_data=0xA5 on the next cycle with no rd_en; rd_en then empties the FIFO.
REQ-031 Reset test: assert rst with count=9 and wr_en=1 -> the next cycle shows count=0, empty=1, and all flags at their reset values.
